// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use hazard detection with a stall FSM
// and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned AW       = 4,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC-1:0]      id_src_vld_i,
  input  logic [NSRC*AW-1:0]   ex_src_i,
  input  logic [AW-1:0]        ex_rd_i,
  input  logic                 ex_regwrite_i,
  input  logic                 ex_memread_i,
  input  logic [AW-1:0]        em_rd_i,
  input  logic                 em_regwrite_i,
  input  logic [AW-1:0]        mwb_rd_i,
  input  logic                 mwb_regwrite_i,
  input  logic                 flush_i,
  output logic [2*NSRC-1:0]    fwd_sel_o,
  output logic                 stall_o,
  output logic                 bubble_o,
  output logic [15:0]          stall_cnt_o
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [3:0] RemInit = 4'(LOAD_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] stall_cnt_q;
  logic        id_match;
  logic        hit;

  function automatic logic excluded(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // EX/MEM has priority over MEM/WB since it holds the younger result.
  always_comb begin
    fwd_sel_o = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (em_regwrite_i && (em_rd_i == ex_src_i[k*AW +: AW]) &&
          !excluded(ex_src_i[k*AW +: AW])) begin
        fwd_sel_o[2*k +: 2] = 2'b10;
      end else if (mwb_regwrite_i && (mwb_rd_i == ex_src_i[k*AW +: AW]) &&
                   !excluded(ex_src_i[k*AW +: AW])) begin
        fwd_sel_o[2*k +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    id_match = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      id_match = id_match | (id_src_vld_i[k] && (id_src_i[k*AW +: AW] == ex_rd_i));
    end
  end

  assign hit = ex_memread_i & ex_regwrite_i & ~excluded(ex_rd_i) & id_match;

  always_comb begin
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    if (rst_i) begin
      stall_o  = 1'b0;
      bubble_o = 1'b0;
    end else if (flush_i) begin
      bubble_o = 1'b1;
    end else if (state_q == StHold) begin
      stall_o  = 1'b1;
      bubble_o = 1'b1;
    end else if (hit) begin
      stall_o  = 1'b1;
      bubble_o = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (flush_i) begin
      state_d = StIdle;
      rem_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit && (LOAD_LAT > 1)) begin
            state_d = StHold;
            rem_d   = RemInit;
          end
        end
        StHold: begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rem_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances with LOAD_LAT 1, 3 and 4
// share stimulus but have independent resets.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst1, rst3, rst4;
  logic [7:0] id_src;
  logic [1:0] id_src_vld;
  logic [7:0] ex_src;
  logic [3:0] ex_rd, em_rd, mwb_rd;
  logic       ex_regwrite, ex_memread, em_regwrite, mwb_regwrite, flush;

  logic [3:0]  fwd1, fwd3, fwd4;
  logic        stall1, stall3, stall4, bub1, bub3, bub4;
  logic [15:0] cnt1, cnt3, cnt4;

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(4), .NSRC(2), .LOAD_LAT(1), .ZERO_REG(1)) u1 (
    .clk_i(clk), .rst_i(rst1), .id_src_i(id_src), .id_src_vld_i(id_src_vld),
    .ex_src_i(ex_src), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .ex_memread_i(ex_memread), .em_rd_i(em_rd), .em_regwrite_i(em_regwrite),
    .mwb_rd_i(mwb_rd), .mwb_regwrite_i(mwb_regwrite), .flush_i(flush),
    .fwd_sel_o(fwd1), .stall_o(stall1), .bubble_o(bub1), .stall_cnt_o(cnt1)
  );

  fwd_hazard_unit #(.AW(4), .NSRC(2), .LOAD_LAT(3), .ZERO_REG(1)) u3 (
    .clk_i(clk), .rst_i(rst3), .id_src_i(id_src), .id_src_vld_i(id_src_vld),
    .ex_src_i(ex_src), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .ex_memread_i(ex_memread), .em_rd_i(em_rd), .em_regwrite_i(em_regwrite),
    .mwb_rd_i(mwb_rd), .mwb_regwrite_i(mwb_regwrite), .flush_i(flush),
    .fwd_sel_o(fwd3), .stall_o(stall3), .bubble_o(bub3), .stall_cnt_o(cnt3)
  );

  fwd_hazard_unit #(.AW(4), .NSRC(2), .LOAD_LAT(4), .ZERO_REG(1)) u4 (
    .clk_i(clk), .rst_i(rst4), .id_src_i(id_src), .id_src_vld_i(id_src_vld),
    .ex_src_i(ex_src), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .ex_memread_i(ex_memread), .em_rd_i(em_rd), .em_regwrite_i(em_regwrite),
    .mwb_rd_i(mwb_rd), .mwb_regwrite_i(mwb_regwrite), .flush_i(flush),
    .fwd_sel_o(fwd4), .stall_o(stall4), .bubble_o(bub4), .stall_cnt_o(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, checks follow #2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_hazard();
    ex_memread  = 1'b1;
    ex_regwrite = 1'b1;
    ex_rd       = 4'd5;
    id_src      = {4'd5, 4'd0};
    id_src_vld  = 2'b10;
  endtask

  task automatic clear_ex();
    ex_memread  = 1'b0;
    ex_regwrite = 1'b0;
    ex_rd       = 4'd0;
    id_src      = 8'h00;
    id_src_vld  = 2'b00;
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    flush = 1'b0;
    ex_src = 8'h00; em_rd = 4'd0; mwb_rd = 4'd0;
    em_regwrite = 1'b0; mwb_regwrite = 1'b0;
    clear_ex();

    // Reset: outputs forced low even with a live hazard on the inputs.
    tick();
    set_load_hazard();
    #2;
    chk("rst_stall", {31'd0, stall1}, 32'd0);
    chk("rst_bubble", {31'd0, bub1}, 32'd0);
    chk("rst_cnt", {16'd0, cnt1}, 32'd0);
    clear_ex();

    // Forwarding works during reset as well; it is purely combinational.
    ex_src = {4'd7, 4'd3}; em_rd = 4'd3; mwb_rd = 4'd3;
    em_regwrite = 1'b1; mwb_regwrite = 1'b1;
    #2 chk("fwd_em_prio", {28'd0, fwd1}, 32'h2);
    em_regwrite = 1'b0;
    #2 chk("fwd_mwb", {28'd0, fwd1}, 32'h1);
    ex_src = {4'd7, 4'd0}; em_rd = 4'd0; mwb_rd = 4'd0;
    em_regwrite = 1'b1; mwb_regwrite = 1'b1;
    #2 chk("fwd_zero_reg", {28'd0, fwd1}, 32'h0);
    ex_src = {4'd7, 4'd3}; em_rd = 4'd3; mwb_rd = 4'd7;
    #2 chk("fwd_both_ops", {28'd0, fwd1}, 32'h6);
    em_regwrite = 1'b0; mwb_regwrite = 1'b0;
    #2 chk("fwd_none", {28'd0, fwd1}, 32'h0);

    // LOAD_LAT = 1
    tick();
    rst1 = 1'b0;
    tick();
    set_load_hazard();
    #2;
    chk("l1_stall_c1", {31'd0, stall1}, 32'd1);
    chk("l1_bubble_c1", {31'd0, bub1}, 32'd1);
    chk("l1_cnt_c1", {16'd0, cnt1}, 32'd0);
    tick();
    clear_ex();
    #2;
    chk("l1_stall_c2", {31'd0, stall1}, 32'd0);
    chk("l1_bubble_c2", {31'd0, bub1}, 32'd0);
    chk("l1_cnt_c2", {16'd0, cnt1}, 32'd1);

    // Invalid operand and excluded register 0 never stall.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 4'd5;
    id_src = {4'd3, 4'd5}; id_src_vld = 2'b10;
    #2 chk("invalid_op", {31'd0, stall1}, 32'd0);
    ex_rd = 4'd0; id_src = {4'd3, 4'd0}; id_src_vld = 2'b01;
    #2 chk("zero_reg_load", {31'd0, stall1}, 32'd0);
    tick();
    clear_ex();
    #2 chk("l1_cnt_hold", {16'd0, cnt1}, 32'd1);
    rst1 = 1'b1;

    // LOAD_LAT = 3
    rst3 = 1'b0;
    tick();
    set_load_hazard();
    #2 chk("l3_stall_c1", {31'd0, stall3}, 32'd1);
    tick();
    clear_ex();
    #2;
    chk("l3_stall_c2", {31'd0, stall3}, 32'd1);
    chk("l3_bubble_c2", {31'd0, bub3}, 32'd1);
    chk("l3_cnt_c2", {16'd0, cnt3}, 32'd1);
    tick();
    #2;
    chk("l3_stall_c3", {31'd0, stall3}, 32'd1);
    chk("l3_cnt_c3", {16'd0, cnt3}, 32'd2);
    tick();
    #2;
    chk("l3_stall_c4", {31'd0, stall3}, 32'd0);
    chk("l3_bubble_c4", {31'd0, bub3}, 32'd0);
    chk("l3_cnt_c4", {16'd0, cnt3}, 32'd3);
    // The consumer now sees the load result on the MEM/WB path.
    ex_src = {4'd5, 4'd0}; mwb_rd = 4'd5; mwb_regwrite = 1'b1;
    #2 chk("l3_fwd_after", {28'd0, fwd3}, 32'h4);
    mwb_regwrite = 1'b0; ex_src = 8'h00; mwb_rd = 4'd0;
    rst3 = 1'b1;

    // LOAD_LAT = 4 with a flush on the second stall cycle.
    rst4 = 1'b0;
    tick();
    set_load_hazard();
    #2 chk("l4_stall_c1", {31'd0, stall4}, 32'd1);
    tick();
    clear_ex();
    flush = 1'b1;
    #2;
    chk("flush_stall", {31'd0, stall4}, 32'd0);
    chk("flush_bubble", {31'd0, bub4}, 32'd1);
    tick();
    flush = 1'b0;
    #2;
    chk("post_flush_stall", {31'd0, stall4}, 32'd0);
    chk("post_flush_bubble", {31'd0, bub4}, 32'd0);
    chk("post_flush_cnt", {16'd0, cnt4}, 32'd1);

    // Flush overrides a hit detected in IDLE.
    set_load_hazard();
    flush = 1'b1;
    #2;
    chk("flush_over_hit_stall", {31'd0, stall4}, 32'd0);
    chk("flush_over_hit_bubble", {31'd0, bub4}, 32'd1);
    tick();
    flush = 1'b0;
    clear_ex();
    #2 chk("flush_over_hit_cnt", {16'd0, cnt4}, 32'd1);

    // Continuous hazard stalls every cycle; 65534 more edges saturate the counter.
    tick();
    set_load_hazard();
    repeat (65534) @(posedge clk);
    #3;
    chk("sat_reach", {16'd0, cnt4}, 32'hFFFF);
    chk("sat_stall", {31'd0, stall4}, 32'd1);
    tick();
    #2 chk("sat_hold", {16'd0, cnt4}, 32'hFFFF);
    // 65535 edges after detect puts the FSM in HOLD with rem = 1.
    clear_ex();
    #1 chk("hold_before_rst", {31'd0, stall4}, 32'd1);
    rst4 = 1'b1;
    #1;
    chk("async_rst_stall", {31'd0, stall4}, 32'd0);
    chk("async_rst_bubble", {31'd0, bub4}, 32'd0);
    chk("async_rst_cnt", {16'd0, cnt4}, 32'd0);
    tick();
    rst4 = 1'b0;
    #2 chk("post_rst_idle", {31'd0, stall4}, 32'd0);
    set_load_hazard();
    #2 chk("post_rst_hit", {31'd0, stall4}, 32'd1);
    tick();
    clear_ex();
    #2 chk("post_rst_cnt", {16'd0, cnt4}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
